// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and defaults for hazard_bubble_ctrl.
//   state_t     - FSM encoding (RUN, STALL, HALT), also used as the debug state output
//   *_DEF       - default parameter values for the block and its interface
//   BUBBLE      - all-zero control bundle at the default CTRL_W
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam int CTRL_W_DEF   = 21;
  localparam int REG_W_DEF    = 5;
  localparam int LOAD_LAT_DEF = 1;
  localparam int CNT_W_DEF    = 16;

  localparam logic [CTRL_W_DEF-1:0] BUBBLE = '0;

endpackage

// File: rtl/hazard_bubble_ctrl_if.sv
// hazard_bubble_ctrl_if: bundles the decode-side inputs and the ID/EX-side
// outputs of hazard_bubble_ctrl.
//   master - the pipeline/control unit side (drives i_*, observes o_* and state)
//   slave  - hazard_bubble_ctrl itself
// There is no valid/ready pair here: i_enable is the only flow qualifier. When
// it is low nothing is consumed and every registered output holds; when it is
// high the inputs are taken on every rising edge.
interface hazard_bubble_ctrl_if
  import hazard_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) ();

  logic              i_enable;
  logic [CTRL_W-1:0] i_ctrl;
  logic              i_halt;
  logic [REG_W-1:0]  i_id_rs;
  logic [REG_W-1:0]  i_id_rt;
  logic              i_id_uses_rt;
  logic              i_ex_mem_read;
  logic [REG_W-1:0]  i_ex_rt;
  logic              i_flush;

  logic [CTRL_W-1:0] o_ctrl;
  logic              o_halt;
  logic              o_pc_write;
  logic              o_ifid_write;
  logic              o_bubble;
  logic              o_halted;
  logic [CNT_W-1:0]  o_bubble_count;
  state_t            state;

  modport master (
    output i_enable, i_ctrl, i_halt, i_id_rs, i_id_rt, i_id_uses_rt,
           i_ex_mem_read, i_ex_rt, i_flush,
    input  o_ctrl, o_halt, o_pc_write, o_ifid_write, o_bubble, o_halted,
           o_bubble_count, state
  );

  modport slave (
    input  i_enable, i_ctrl, i_halt, i_id_rs, i_id_rt, i_id_uses_rt,
           i_ex_mem_read, i_ex_rt, i_flush,
    output o_ctrl, o_halt, o_pc_write, o_ifid_write, o_bubble, o_halted,
           o_bubble_count, state
  );

endinterface

// File: rtl/load_use_detect.sv
// load_use_detect: combinational load-use hazard compare.
//   ex_mem_read/ex_rt - load in EX and its destination register
//   id_rs/id_rt       - sources of the instruction in ID
//   id_uses_rt        - the ID instruction actually reads rt
//   hz                - ID depends on the load result
// Register 0 is hard-wired, so a load targeting it never creates a dependency.
module load_use_detect #(
  parameter int REG_W = 5
) (
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             hz
);

  always_comb begin
    hz = ex_mem_read && (ex_rt != '0) &&
         ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  end

endmodule

// File: rtl/hazard_bubble_ctrl.sv
// hazard_bubble_ctrl: ID/EX control-bundle register with load-use stall,
// flush bubbles, sticky HALT and a saturating bubble counter.
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   bus (slave)    - decode inputs, ID/EX outputs, PC/IF-ID write enables,
//                    debug state
// LOAD_LAT legal range is 1..8.
module hazard_bubble_ctrl
  import hazard_pkg::*;
#(
  parameter int CTRL_W   = CTRL_W_DEF,
  parameter int REG_W    = REG_W_DEF,
  parameter int LOAD_LAT = LOAD_LAT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input logic               i_clk,
  input logic               i_rst_n,
  hazard_bubble_ctrl_if.slave bus
);

  localparam int               SC_W    = $clog2(LOAD_LAT) + 1;
  localparam logic [SC_W-1:0]  LAT_M1  = SC_W'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CTRL_W-1:0] NOP    = CTRL_W'(BUBBLE);

  state_t            state;
  logic [SC_W-1:0]   cnt;
  logic [CTRL_W-1:0] ctrl_q;
  logic              halt_q;
  logic              bubble_q;
  logic              halted_q;
  logic [CNT_W-1:0]  count_q;

  logic              hz;
  logic              load_bubble;
  logic              advance;

  load_use_detect #(.REG_W(REG_W)) u_load_use_detect (
    .ex_mem_read (bus.i_ex_mem_read),
    .ex_rt       (bus.i_ex_rt),
    .id_rs       (bus.i_id_rs),
    .id_rt       (bus.i_id_rt),
    .id_uses_rt  (bus.i_id_uses_rt),
    .hz          (hz)
  );

  // Same-cycle decision: does this edge load a bubble, and may PC/IF-ID move.
  // Reset and a low enable both freeze the front end.
  always_comb begin
    load_bubble = 1'b0;
    advance     = 1'b0;
    if (i_rst_n && bus.i_enable) begin
      unique case (state)
        RUN: begin
          if (bus.i_flush) begin
            load_bubble = 1'b1;
            advance     = 1'b1;
          end else if (hz) begin
            load_bubble = 1'b1;
          end else if (!bus.i_halt) begin
            advance     = 1'b1;
          end
        end
        STALL: begin
          load_bubble = 1'b1;
          advance     = bus.i_flush;
        end
        default: begin
          load_bubble = 1'b0;
          advance     = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= RUN;
      cnt      <= '0;
      ctrl_q   <= NOP;
      halt_q   <= 1'b0;
      bubble_q <= 1'b0;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else if (bus.i_enable) begin
      unique case (state)
        RUN: begin
          if (bus.i_flush) begin
            ctrl_q   <= NOP;
            halt_q   <= 1'b0;
            bubble_q <= 1'b1;
          end else if (hz) begin
            ctrl_q   <= NOP;
            halt_q   <= 1'b0;
            bubble_q <= 1'b1;
            cnt      <= LAT_M1;
            // A single-cycle latency is fully covered by this bubble.
            if (LOAD_LAT > 1) state <= STALL;
          end else if (bus.i_halt) begin
            ctrl_q   <= bus.i_ctrl;
            halt_q   <= 1'b1;
            bubble_q <= 1'b0;
            halted_q <= 1'b1;
            state    <= HALT;
          end else begin
            ctrl_q   <= bus.i_ctrl;
            halt_q   <= 1'b0;
            bubble_q <= 1'b0;
          end
        end
        STALL: begin
          ctrl_q   <= NOP;
          halt_q   <= 1'b0;
          bubble_q <= 1'b1;
          if (bus.i_flush) begin
            cnt   <= '0;
            state <= RUN;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == SC_W'(1)) state <= RUN;
          end
        end
        HALT: begin
          ctrl_q   <= NOP;
          halt_q   <= 1'b0;
          bubble_q <= 1'b0;
          halted_q <= 1'b1;
        end
        default: begin
          state <= RUN;
        end
      endcase
      if (load_bubble && (count_q != CNT_MAX)) count_q <= count_q + 1'b1;
    end
  end

  assign bus.o_ctrl         = ctrl_q;
  assign bus.o_halt         = halt_q;
  assign bus.o_bubble       = bubble_q;
  assign bus.o_halted       = halted_q;
  assign bus.o_bubble_count = count_q;
  assign bus.o_pc_write     = advance;
  assign bus.o_ifid_write   = advance;
  assign bus.state          = state;

endmodule

// File: tb/tb_hazard_bubble_ctrl.sv
// tb_hazard_bubble_ctrl: directed bench for hazard_bubble_ctrl. Three
// instances share one stimulus: a (LOAD_LAT=1), b (LOAD_LAT=3),
// c (LOAD_LAT=4, CNT_W=2); each scenario resets and checks one of them.
module tb_hazard_bubble_ctrl;
  import hazard_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic        enable, halt, uses_rt, mem_read, flush;
  logic [20:0] ctrl;
  logic [4:0]  rs, rt, ex_rt;

  hazard_bubble_ctrl_if #(.CTRL_W(21), .REG_W(5), .CNT_W(16)) ifa ();
  hazard_bubble_ctrl_if #(.CTRL_W(21), .REG_W(5), .CNT_W(16)) ifb ();
  hazard_bubble_ctrl_if #(.CTRL_W(21), .REG_W(5), .CNT_W(2))  ifc ();

  assign ifa.i_enable = enable;  assign ifa.i_ctrl = ctrl;  assign ifa.i_halt = halt;
  assign ifa.i_id_rs = rs;  assign ifa.i_id_rt = rt;  assign ifa.i_id_uses_rt = uses_rt;
  assign ifa.i_ex_mem_read = mem_read;  assign ifa.i_ex_rt = ex_rt;  assign ifa.i_flush = flush;
  assign ifb.i_enable = enable;  assign ifb.i_ctrl = ctrl;  assign ifb.i_halt = halt;
  assign ifb.i_id_rs = rs;  assign ifb.i_id_rt = rt;  assign ifb.i_id_uses_rt = uses_rt;
  assign ifb.i_ex_mem_read = mem_read;  assign ifb.i_ex_rt = ex_rt;  assign ifb.i_flush = flush;
  assign ifc.i_enable = enable;  assign ifc.i_ctrl = ctrl;  assign ifc.i_halt = halt;
  assign ifc.i_id_rs = rs;  assign ifc.i_id_rt = rt;  assign ifc.i_id_uses_rt = uses_rt;
  assign ifc.i_ex_mem_read = mem_read;  assign ifc.i_ex_rt = ex_rt;  assign ifc.i_flush = flush;

  hazard_bubble_ctrl #(.CTRL_W(21), .REG_W(5), .LOAD_LAT(1), .CNT_W(16)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .bus(ifa));
  hazard_bubble_ctrl #(.CTRL_W(21), .REG_W(5), .LOAD_LAT(3), .CNT_W(16)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .bus(ifb));
  hazard_bubble_ctrl #(.CTRL_W(21), .REG_W(5), .LOAD_LAT(4), .CNT_W(2)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .bus(ifc));

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    enable = 1'b1; ctrl = '0; halt = 1'b0; rs = '0; rt = '0;
    uses_rt = 1'b0; mem_read = 1'b0; ex_rt = '0; flush = 1'b0;
  endtask

  // Returns 1 ns after a rising edge, inputs stable from there on.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic load_hz(input logic [4:0] r);
    mem_read = 1'b1; ex_rt = r; rs = r;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle();
    rst_n = 1'b0;
    #2;
    // Reset state, before any clock edge.
    check("rst_ctrl",   32'(ifa.o_ctrl), 32'h0);
    check("rst_pcw",    32'(ifa.o_pc_write), 32'h0);
    check("rst_ifidw",  32'(ifa.o_ifid_write), 32'h0);
    check("rst_bubble", 32'(ifa.o_bubble), 32'h0);
    check("rst_halted", 32'(ifa.o_halted), 32'h0);
    check("rst_count",  32'(ifa.o_bubble_count), 32'h0);
    check("rst_state",  32'(ifa.state), 32'(RUN));

    // LOAD_LAT=1: lw r3 in EX, ID reads rs=3 -> one bubble.
    do_reset();
    ctrl = 21'h111; load_hz(5'd3);
    #1 check("l1_pcw", 32'(ifa.o_pc_write), 32'h0);
    check("l1_ifidw", 32'(ifa.o_ifid_write), 32'h0);
    tick();
    check("l1_ctrl", 32'(ifa.o_ctrl), 32'h0);
    check("l1_bub", 32'(ifa.o_bubble), 32'h1);
    check("l1_cnt", 32'(ifa.o_bubble_count), 32'd1);
    mem_read = 1'b0; ctrl = 21'h0AB;
    #1 check("l1_pcw_rel", 32'(ifa.o_pc_write), 32'h1);
    tick();
    check("l1_issue", 32'(ifa.o_ctrl), 32'h0AB);
    check("l1_bub0", 32'(ifa.o_bubble), 32'h0);
    // hz and flush together: a single bubble, PC advances.
    load_hz(5'd3); flush = 1'b1;
    #1 check("hzfl_pcw", 32'(ifa.o_pc_write), 32'h1);
    tick();
    check("hzfl_cnt", 32'(ifa.o_bubble_count), 32'd2);
    check("hzfl_bub", 32'(ifa.o_bubble), 32'h1);

    // LOAD_LAT=3: load rt=5, ID uses rt=5 -> 3 bubbles then 0x1A5.
    do_reset();
    ctrl = 21'h1A5; mem_read = 1'b1; ex_rt = 5'd5; rt = 5'd5; uses_rt = 1'b1; rs = 5'd1;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("l3_pcw%0d", i), 32'(ifb.o_pc_write), 32'h0);
      tick();
      mem_read = 1'b0;
      check($sformatf("l3_ctrl%0d", i), 32'(ifb.o_ctrl), 32'h0);
      check($sformatf("l3_bub%0d", i), 32'(ifb.o_bubble), 32'h1);
    end
    #1 check("l3_pcw_rel", 32'(ifb.o_pc_write), 32'h1);
    tick();
    check("l3_issue", 32'(ifb.o_ctrl), 32'h1A5);
    check("l3_bub0", 32'(ifb.o_bubble), 32'h0);
    check("l3_cnt", 32'(ifb.o_bubble_count), 32'd3);

    // No-stall cases.
    do_reset();
    ctrl = 21'h055; mem_read = 1'b1; ex_rt = 5'd0; rs = 5'd0;
    #1 check("r0_pcw", 32'(ifa.o_pc_write), 32'h1);
    tick();
    check("r0_ctrl", 32'(ifa.o_ctrl), 32'h055);
    ctrl = 21'h066; ex_rt = 5'd7; rt = 5'd7; uses_rt = 1'b0; rs = 5'd2;
    #1 check("nort_pcw", 32'(ifa.o_pc_write), 32'h1);
    tick();
    check("nort_ctrl", 32'(ifa.o_ctrl), 32'h066);
    check("nort_cnt", 32'(ifa.o_bubble_count), 32'd0);

    // LOAD_LAT=4: flush on the 2nd stall cycle aborts the stall.
    do_reset();
    ctrl = 21'h0CC; load_hz(5'd4);
    tick();
    mem_read = 1'b0; flush = 1'b1;
    check("fl_state_stall", 32'(ifc.state), 32'(STALL));
    #1 check("fl_pcw", 32'(ifc.o_pc_write), 32'h1);
    check("fl_ifidw", 32'(ifc.o_ifid_write), 32'h1);
    tick();
    check("fl_bub", 32'(ifc.o_bubble), 32'h1);
    check("fl_cnt", 32'(ifc.o_bubble_count), 32'd2);
    check("fl_state_run", 32'(ifc.state), 32'(RUN));
    flush = 1'b0; ctrl = 21'h0DD;
    tick();
    check("fl_issue", 32'(ifc.o_ctrl), 32'h0DD);

    // HALT: one cycle of o_halt, then sticky zeros; flush ignored.
    do_reset();
    ctrl = 21'h1F0; halt = 1'b1;
    #1 check("h_pcw", 32'(ifa.o_pc_write), 32'h0);
    tick();
    check("h_ctrl", 32'(ifa.o_ctrl), 32'h1F0);
    check("h_halt", 32'(ifa.o_halt), 32'h1);
    halt = 1'b0; ctrl = 21'h077; flush = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1 check($sformatf("h_pcw_held%0d", i), 32'(ifa.o_pc_write), 32'h0);
      tick();
      check($sformatf("h_ctrl0_%0d", i), 32'(ifa.o_ctrl), 32'h0);
      check($sformatf("h_halt0_%0d", i), 32'(ifa.o_halt), 32'h0);
      check($sformatf("h_halted%0d", i), 32'(ifa.o_halted), 32'h1);
    end
    check("h_cnt", 32'(ifa.o_bubble_count), 32'd0);
    flush = 1'b0; ctrl = 21'h033;
    #2 rst_n = 1'b0;
    #1 check("h_arst_halted", 32'(ifa.o_halted), 32'h0);
    check("h_arst_state", 32'(ifa.state), 32'(RUN));
    #1 rst_n = 1'b1;
    tick();
    check("h_resume", 32'(ifa.o_ctrl), 32'h033);

    // CNT_W=2: five flushes saturate the counter at 3.
    do_reset();
    flush = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("sat_cnt", 32'(ifc.o_bubble_count), 32'd3);

    // i_enable=0 mid-STALL holds everything for 4 cycles.
    do_reset();
    ctrl = 21'h0EE; load_hz(5'd6);
    tick();
    mem_read = 1'b0;
    tick();
    check("en_cnt_pre", 32'(ifc.o_bubble_count), 32'd2);
    enable = 1'b0; flush = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("en_pcw%0d", i), 32'(ifc.o_pc_write), 32'h0);
      tick();
      check($sformatf("en_ctrl%0d", i), 32'(ifc.o_ctrl), 32'h0);
      check($sformatf("en_bub%0d", i), 32'(ifc.o_bubble), 32'h1);
      check($sformatf("en_cnt%0d", i), 32'(ifc.o_bubble_count), 32'd2);
      check($sformatf("en_state%0d", i), 32'(ifc.state), 32'(STALL));
    end
    enable = 1'b1; flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1 check($sformatf("en_stall_pcw%0d", i), 32'(ifc.o_pc_write), 32'h0);
      tick();
      check($sformatf("en_stall_bub%0d", i), 32'(ifc.o_bubble), 32'h1);
    end
    #1 check("en_rel_pcw", 32'(ifc.o_pc_write), 32'h1);
    tick();
    check("en_issue", 32'(ifc.o_ctrl), 32'h0EE);
    check("en_cnt_sat", 32'(ifc.o_bubble_count), 32'd3);

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_bubble_ctrl.md
# hazard_bubble_ctrl

Parametrised ID/EX control-bundle stage with integrated load-use hazard detection and bubble insertion. It sits between the control unit and the ID/EX pipeline register and replaces the purely combinational risk mux. It registers the decoded control bundle and holds PC and IF/ID for a configurable number of load-latency cycles. It also handles flush bubbles for taken branches and jumps, latches HALT until reset, and counts inserted bubbles for the debug unit.

## Interface
Parameters:
- CTRL_W, 21: width of decoded control bundle, excluding halt.
- REG_W, 5: register address width.
- LOAD_LAT, 1: bubbles per load-use hazard. Legal range 1..8.
- CNT_W, 16: bubble counter width.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_enable  in  1  debug step/run enable; 0 freezes the block.
- i_ctrl  in  CTRL_W  decoded control bundle from the control unit.
- i_halt  in  1  decoded HALT.
- i_id_rs, i_id_rt  in  REG_W  source registers of the instruction in ID.
- i_id_uses_rt  in  1  the ID instruction reads rt.
- i_ex_mem_read  in  1  the instruction in EX is a load.
- i_ex_rt  in  REG_W  load destination in EX.
- i_flush  in  1  taken branch or jump resolved this cycle.
- o_ctrl  out  CTRL_W  registered bundle to ID/EX; all-zero is a bubble.
- o_halt  out  1  registered halt bit to ID/EX.
- o_pc_write  out  1  PC update enable (combinational).
- o_ifid_write  out  1  IF/ID update enable (combinational).
- o_bubble  out  1  registered; 1 when o_ctrl currently holds an inserted bubble.
- o_halted  out  1  registered; the block is in HALT.
- o_bubble_count  out  CNT_W  saturating count of inserted bubbles.

## Operation
- Hazard condition `hz` = i_ex_mem_read && i_ex_rt != 0 && (i_ex_rt == i_id_rs || (i_id_uses_rt && i_ex_rt == i_id_rt)).
- The FSM has three states: RUN, STALL and HALT. Stall counter width is clog2(LOAD_LAT)+1.
- RUN decisions, in priority order:
  - i_flush: load a bubble, pc_write=1, ifid_write=1. Stay in RUN.
  - hz: load a bubble, pc_write=0, ifid_write=0, cnt←LOAD_LAT-1. Go to STALL if LOAD_LAT>1.
  - i_halt: load i_ctrl with o_halt=1, pc_write=0, ifid_write=0. Go to HALT.
  - Otherwise: load i_ctrl with o_halt=0, pc_write=1, ifid_write=1.
- STALL:
  - Each cycle: load a bubble, pc_write=0, ifid_write=0, cnt decrements. At cnt==1 the next state is RUN.
  - i_flush aborts the stall: bubble, pc_write=1, ifid_write=1, go to RUN.
  - hz is ignored while in STALL.
- HALT:
  - o_ctrl=0, o_halt=0, pc_write=0, ifid_write=0, o_halted=1.
  - HALT is left only by reset. i_flush and hz are ignored.
- i_enable=0 overrides everything, including flush:
  - o_ctrl, o_halt, o_bubble, state, cnt and o_bubble_count all hold.
  - pc_write=0 and ifid_write=0.
- o_bubble_count increments by 1 for every bubble loaded by flush, hz or STALL. It saturates at 2^CNT_W-1. HALT zeros are not counted.
- hz and i_flush asserted together count as a single bubble.

## Timing
- o_ctrl, o_halt, o_bubble and o_halted have 1-cycle latency from the inputs sampled at the edge.
- o_pc_write and o_ifid_write depend combinationally on state, hz, i_flush, i_halt and i_enable in the same cycle.
- A load-use hazard yields exactly LOAD_LAT consecutive bubbles with pc_write=0. The dependent instruction issues on the following edge.
- Reset values:
  - o_ctrl=0, o_halt=0, o_bubble=0, o_halted=0, o_bubble_count=0, state=RUN, cnt=0.
  - o_pc_write=0 and o_ifid_write=0 while i_rst_n=0.
- Reset asserted mid-STALL or in HALT takes effect immediately (asynchronous). The block resumes in RUN on the first edge after release.

## Structure
- Package hazard_pkg holds the state enum (RUN, STALL, HALT), the bubble constant '0 sized CTRL_W, and the default parameter values.
- Sub-module load_use_detect: pure combinational `hz` compare, reused by the forwarding unit.
- The top level holds the FSM, stall counter, control register and bubble counter.

## Test plan
- LOAD_LAT=1, lw r3 in EX, ID reads rs=3 → one bubble (o_ctrl=0, o_bubble=1), pc_write=0 for 1 cycle, count=1.
- LOAD_LAT=3, load rt=5, ID uses rt=5 → 3 bubbles, pc_write low 3 cycles, then ID ctrl 0x1A5 passes through, count=3.
- i_ex_rt=0 with ID rs=0 → no stall. With i_id_uses_rt=0 and rt matching → no stall.
- LOAD_LAT=4, flush on the 2nd stall cycle → bubble, pc_write=1 same cycle, RUN next, count=2.
- i_halt → o_halt=1 for one cycle, then o_halted=1 and o_ctrl=0 indefinitely. Flush ignored. Async reset mid-HALT clears all outputs.
- CNT_W=2, 5 flushes → count saturates at 3. i_enable=0 mid-STALL holds cnt and o_ctrl for 4 cycles, then the stall completes normally.
